// File: rtl/m_dmem_lsu_if.sv
// ---------------------------------------------------------------------------
// m_dmem_lsu_if
//   Bundle of every signal between a core memory stage, the load/store unit
//   and one port of the dual-port data memory. The member names are the
//   m_dmem_lsu port names, so the _i/_o suffixes are relative to the LSU.
//
//   Parameter
//     DMEM_ADDRW    word-address width of the dmem port (default `DMEM_ADDRW)
//
//   Core request    req_valid_i, req_ready_o, req_we_i, req_funct3_i,
//                   req_addr_i, req_wdata_i
//   Core response   rsp_valid_o, rsp_rdata_o, rsp_err_o
//   Memory port     dmem_re_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
//                   dmem_wstrb_o, dmem_rdata_i
//
//   Modports
//     slave   the LSU view (takes requests, drives the memory port)
//     master  the environment view (core plus memory)
// ---------------------------------------------------------------------------
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 10
`endif

interface m_dmem_lsu_if #(
    parameter int DMEM_ADDRW = `DMEM_ADDRW
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [31:0]           req_addr_i;
    logic [31:0]           req_wdata_i;

    logic                  rsp_valid_o;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;

    logic                  dmem_re_o;
    logic                  dmem_we_o;
    logic [DMEM_ADDRW-1:0] dmem_addr_o;
    logic [31:0]           dmem_wdata_o;
    logic [3:0]            dmem_wstrb_o;
    logic [31:0]           dmem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  dmem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output dmem_re_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output dmem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  dmem_re_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o
    );
endinterface

// File: rtl/m_dmem_lsu.sv
// ---------------------------------------------------------------------------
// m_dmem_lsu
//   Load/store initiator for one port of the dual-port data memory
//   (registered read, byte-strobe write). Takes RV32 load/store requests from
//   a core over a valid/ready handshake, drives the memory port, and returns
//   aligned, sign- or zero-extended load data as a one-cycle response pulse.
//
//   Parameters
//     DMEM_ADDRW    word-address width of the dmem port
//     DMEM_ENTRIES  number of 32-bit words; informational, addresses wrap
//                   modulo 2^DMEM_ADDRW
//
//   Ports
//     clk_i         single clock
//     rst_i         asynchronous, active-high reset
//     bus           m_dmem_lsu_if.slave: request, response and memory port
//
//   Configuration macro
//     DMEM_LSU_MISALIGN_EN  when defined, misaligned half/word accesses that
//                           cross a word boundary are split over two words
//                           (SECOND state). When undefined, any misaligned
//                           half/word access returns err without touching
//                           memory and no split hardware is built.
// ---------------------------------------------------------------------------
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 10
`endif
`ifndef DMEM_ENTRIES
`define DMEM_ENTRIES (1 << `DMEM_ADDRW)
`endif

module m_dmem_lsu #(
    parameter int DMEM_ADDRW   = `DMEM_ADDRW,
    parameter int DMEM_ENTRIES = `DMEM_ENTRIES
) (
    input  logic         clk_i,
    input  logic         rst_i,
    m_dmem_lsu_if.slave  bus
);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  accept;
    logic [1:0]            req_off;
    logic [DMEM_ADDRW-1:0] req_word;
    logic                  f3_legal;
    logic                  misaligned;
    logic                  req_legal;
    logic [3:0]            base_strb;
    logic [3:0]            strb_lo;
    logic [31:0]           wdata_lo;
`ifdef DMEM_LSU_MISALIGN_EN
    logic [7:0]            strb_wide;
    logic [63:0]           wdata_wide;
    logic [3:0]            strb_hi;
    logic [31:0]           wdata_hi;
    logic                  req_split;
`endif

    // Response registers
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_load_q;
    logic [1:0]            rsp_off_q;
    logic [2:0]            rsp_f3_q;

    // Memory-port drive, assembled combinationally
    logic                  dmem_re;
    logic                  dmem_we;
    logic [DMEM_ADDRW-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [3:0]            dmem_wstrb;

    // Response data path
    logic [31:0]           aligned_data;
    logic [31:0]           ext_data;
    logic [31:0]           rsp_rdata;

`ifdef DMEM_LSU_MISALIGN_EN
    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;

    // Second half of a split access, captured at accept
    logic                  split_q;
    logic                  sec_we_q;
    logic [DMEM_ADDRW-1:0] sec_word_q;
    logic [3:0]            sec_strb_q;
    logic [31:0]           sec_wdata_q;
    logic [31:0]           lo_q;
    logic [31:0]           lo_word;
`endif

    // Address bits above the word index select nothing on this port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr_i[31:DMEM_ADDRW+2];

`ifdef DMEM_LSU_MISALIGN_EN
    assign bus.req_ready_o = (state_q == IDLE);
`else
    assign bus.req_ready_o = 1'b1;
`endif

    assign accept = bus.req_valid_i & bus.req_ready_o;

    // Classify the request and pre-shift store data/strobes into byte lanes.
    // Shifting into a 64-bit window puts the bytes that spill past the word
    // boundary into the upper half, which is exactly the second word's lanes.
    always_comb begin
        req_off  = bus.req_addr_i[1:0];
        req_word = bus.req_addr_i[DMEM_ADDRW+1:2];

        // Loads: LB LH LW LBU LHU. Stores: SB SH SW.
        if (bus.req_we_i) begin
            f3_legal = (bus.req_funct3_i[2] == 1'b0) && (bus.req_funct3_i[1:0] != 2'b11);
        end else begin
            f3_legal = (bus.req_funct3_i[1:0] != 2'b11) && (bus.req_funct3_i != 3'b110);
        end

        case (bus.req_funct3_i[1:0])
            2'b00: begin
                misaligned = 1'b0;
                base_strb  = 4'b0001;
            end
            2'b01: begin
                misaligned = req_off[0];
                base_strb  = 4'b0011;
            end
            default: begin
                misaligned = (req_off != 2'b00);
                base_strb  = 4'b1111;
            end
        endcase

`ifdef DMEM_LSU_MISALIGN_EN
        req_legal  = f3_legal;
        strb_wide  = {4'b0000, base_strb} << req_off;
        wdata_wide = {32'h0000_0000, bus.req_wdata_i} << {req_off, 3'b000};
        strb_lo    = strb_wide[3:0];
        strb_hi    = strb_wide[7:4];
        wdata_lo   = wdata_wide[31:0];
        wdata_hi   = wdata_wide[63:32];
        // A misaligned half at offset 1 still fits in one word, so only a
        // spill into the upper lanes forces a second access.
        req_split  = (strb_hi != 4'b0000);
`else
        req_legal  = f3_legal & ~misaligned;
        strb_lo    = base_strb << req_off;
        wdata_lo   = bus.req_wdata_i << {req_off, 3'b000};
`endif
    end

`ifdef DMEM_LSU_MISALIGN_EN
    // State register: reset aborts any split access, so a pending second
    // half is simply dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory-port drive. IDLE issues the first (or only)
    // access straight from the request; SECOND replays the captured upper
    // lanes at the following word.
    always_comb begin
        state_d    = state_q;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        case (state_q)
            IDLE: begin
                if (accept && req_legal) begin
                    dmem_re   = ~bus.req_we_i;
                    dmem_we   = bus.req_we_i;
                    dmem_addr = req_word;
                    if (bus.req_we_i) begin
                        dmem_wdata = wdata_lo;
                        dmem_wstrb = strb_lo;
                    end
                    if (req_split) begin
                        state_d = SECOND;
                    end
                end
            end
            SECOND: begin
                dmem_re   = ~sec_we_q;
                dmem_we   = sec_we_q;
                dmem_addr = sec_word_q;
                if (sec_we_q) begin
                    dmem_wdata = sec_wdata_q;
                    dmem_wstrb = sec_strb_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Second-half bookkeeping. The low word of a split load arrives during
    // SECOND and is parked in lo_q until the high word shows up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            split_q     <= 1'b0;
            sec_we_q    <= 1'b0;
            sec_word_q  <= '0;
            sec_strb_q  <= '0;
            sec_wdata_q <= '0;
            lo_q        <= '0;
        end else begin
            if (accept) begin
                split_q     <= req_legal & req_split;
                sec_we_q    <= bus.req_we_i;
                sec_word_q  <= req_word + DMEM_ADDRW'(1);
                sec_strb_q  <= strb_hi;
                sec_wdata_q <= wdata_hi;
            end
            if (state_q == SECOND) begin
                lo_q <= bus.dmem_rdata_i;
            end
        end
    end
`else
    // Without split support every legal access completes in one memory cycle.
    always_comb begin
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        if (accept && req_legal) begin
            dmem_re   = ~bus.req_we_i;
            dmem_we   = bus.req_we_i;
            dmem_addr = req_word;
            if (bus.req_we_i) begin
                dmem_wdata = wdata_lo;
                dmem_wstrb = strb_lo;
            end
        end
    end
`endif

    // Response timing and the fields needed to format load data. A split
    // access holds its pulse back one cycle; errors respond like aligned ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_off_q   <= '0;
            rsp_f3_q    <= '0;
        end else begin
`ifdef DMEM_LSU_MISALIGN_EN
            rsp_valid_q <= (accept && !(req_legal && req_split)) || (state_q == SECOND);
`else
            rsp_valid_q <= accept;
`endif
            if (accept) begin
                rsp_err_q  <= ~req_legal;
                rsp_load_q <= ~bus.req_we_i;
                rsp_off_q  <= req_off;
                rsp_f3_q   <= bus.req_funct3_i;
            end
        end
    end

    // Load formatting: right-justify the addressed bytes, then extend.
    // For a split load the low bytes come from lo_q and the high bytes from
    // the word being returned now; the 64-bit shift merges them.
    always_comb begin
`ifdef DMEM_LSU_MISALIGN_EN
        lo_word      = split_q ? lo_q : bus.dmem_rdata_i;
        aligned_data = 32'({bus.dmem_rdata_i, lo_word} >> {rsp_off_q, 3'b000});
`else
        aligned_data = bus.dmem_rdata_i >> {rsp_off_q, 3'b000};
`endif
        case (rsp_f3_q[1:0])
            2'b00: ext_data = rsp_f3_q[2] ? {24'h000000, aligned_data[7:0]}
                                          : {{24{aligned_data[7]}}, aligned_data[7:0]};
            2'b01: ext_data = rsp_f3_q[2] ? {16'h0000, aligned_data[15:0]}
                                          : {{16{aligned_data[15]}}, aligned_data[15:0]};
            default: ext_data = aligned_data;
        endcase
        rsp_rdata = (rsp_valid_q && rsp_load_q && !rsp_err_q) ? ext_data : 32'h0000_0000;
    end

    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_err_o    = rsp_valid_q & rsp_err_q;
    assign bus.rsp_rdata_o  = rsp_rdata;

    assign bus.dmem_re_o    = dmem_re;
    assign bus.dmem_we_o    = dmem_we;
    assign bus.dmem_addr_o  = dmem_addr;
    assign bus.dmem_wdata_o = dmem_wdata;
    assign bus.dmem_wstrb_o = dmem_wstrb;

endmodule

// File: tb/tb_m_dmem_lsu.sv
// ---------------------------------------------------------------------------
// tb_m_dmem_lsu
//   Drives m_dmem_lsu with directed and random loads/stores. A behavioural
//   memory device sits on the dmem port; a byte-addressed reference memory
//   predicts every response (latency, err, rdata). Works with and without
//   DMEM_LSU_MISALIGN_EN defined.
// ---------------------------------------------------------------------------
module tb_m_dmem_lsu;
    localparam int AW     = 6;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 4 * NWORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations of the accept cycle and the most recent response
    logic        t_ready;
    logic        t_re;
    logic        t_we;
    logic [31:0] t_addr;
    logic [3:0]  t_strb;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    logic        t_err;

    m_dmem_lsu_if #(.DMEM_ADDRW(AW)) bus ();

    m_dmem_lsu #(
        .DMEM_ADDRW   (AW),
        .DMEM_ENTRIES (NWORDS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory device on the port: registered read, byte-strobe write
    logic [31:0] mem_words [NWORDS] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bus.dmem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_wstrb_o[b]) mem_words[bus.dmem_addr_o][8*b +: 8] <= bus.dmem_wdata_o[8*b +: 8];
            end
        end
        if (bus.dmem_re_o) bus.dmem_rdata_i <= mem_words[bus.dmem_addr_o];
    end

    // Reference: flat byte memory, addresses wrap modulo its size
    logic [7:0] ref_mem [NBYTES] = '{default: 8'h00};

    task automatic refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic exp_err,
                            output logic [31:0] exp_rdata, output int exp_lat);
        int          size;
        int          base;
        logic [31:0] raw;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        exp_lat   = 1;
        size      = 1 << f3[1:0];
        base      = int'(addr % NBYTES);
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) begin
            exp_err = 1'b1;
        end else if ((addr % size) != 0) begin
`ifdef DMEM_LSU_MISALIGN_EN
            if (int'(addr % 4) + size > 4) exp_lat = 2;
`else
            exp_err = 1'b1;
`endif
        end
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[(base + i) % NBYTES] = wdata[8*i +: 8];
            end else begin
                raw = 32'h0;
                for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_mem[(base + i) % NBYTES];
                if (!f3[2] && size == 1) exp_rdata = {{24{raw[7]}}, raw[7:0]};
                else if (!f3[2] && size == 2) exp_rdata = {{16{raw[15]}}, raw[15:0]};
                else exp_rdata = raw;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // One request, entered and left just after a rising edge. Captures the
    // accept-cycle memory drive, then waits (bounded) for the response.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          lat;
        refModel(we, f3, addr, wdata, exp_err, exp_rdata, exp_lat);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        @(negedge clk);
        t_ready = bus.req_ready_o;
        t_re    = bus.dmem_re_o;
        t_we    = bus.dmem_we_o;
        t_addr  = 32'(bus.dmem_addr_o);
        t_strb  = bus.dmem_wstrb_o;
        t_wdata = bus.dmem_wdata_o;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        lat = 1;
        @(negedge clk);
        while (bus.rsp_valid_o !== 1'b1 && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        t_rdata = bus.rsp_rdata_o;
        t_err   = bus.rsp_err_o;
        checkOutput({tag, "/ready"}, 32'(t_ready), 32'd1);
        checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "/err"}, 32'(t_err), 32'(exp_err));
        checkOutput({tag, "/rdata"}, t_rdata, exp_rdata);
        @(posedge clk);
        #1;
    endtask

    logic        b_we    [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] b_addr  [3] = '{32'h10, 32'h14, 32'h24};
    logic [31:0] b_wdata [3] = '{32'h0, 32'h0, 32'h1234_5678};
    logic        b_err   [3];
    logic [31:0] b_rdata [3];
    int          b_lat   [3];
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          k;

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = 32'h0;
        bus.req_wdata_i  = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset/ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("reset/rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("reset/dmem_re_we", {30'd0, bus.dmem_re_o, bus.dmem_we_o}, 32'd0);
        checkOutput("reset/rsp_rdata", bus.rsp_rdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word store then load
        applyStimulus("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        checkOutput("sw_10/we", 32'(t_we), 32'd1);
        checkOutput("sw_10/wstrb", 32'(t_strb), 32'hF);
        checkOutput("sw_10/addr", t_addr, 32'd4);
        applyStimulus("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("lw_10/const", t_rdata, 32'hDEAD_BEEF);

        // Byte/half extension
        applyStimulus("lb_13", 1'b0, 3'b000, 32'h13, 32'h0);
        checkOutput("lb_13/const", t_rdata, 32'hFFFF_FFDE);
        applyStimulus("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
        checkOutput("lbu_13/const", t_rdata, 32'h0000_00DE);
        applyStimulus("lh_12", 1'b0, 3'b001, 32'h12, 32'h0);
        checkOutput("lh_12/const", t_rdata, 32'hFFFF_DEAD);

        // Byte store lane placement
        applyStimulus("sb_11", 1'b1, 3'b000, 32'h11, 32'h0000_0055);
        checkOutput("sb_11/wstrb", 32'(t_strb), 32'b0010);
        checkOutput("sb_11/lane1", 32'(t_wdata[15:8]), 32'h55);
        applyStimulus("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0);
        checkOutput("lw_10b/const", t_rdata, 32'hDEAD_55EF);

        // Back-to-back LW, LW, SW with valid held high
        for (int i = 0; i < 3; i++) refModel(b_we[i], 3'b010, b_addr[i], b_wdata[i], b_err[i], b_rdata[i], b_lat[i]);
        for (int i = 0; i < 3; i++) begin
            bus.req_valid_i  = 1'b1;
            bus.req_we_i     = b_we[i];
            bus.req_funct3_i = 3'b010;
            bus.req_addr_i   = b_addr[i];
            bus.req_wdata_i  = b_wdata[i];
            @(negedge clk);
            checkOutput("b2b/ready", 32'(bus.req_ready_o), 32'd1);
            if (i > 0) begin
                checkOutput("b2b/rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
                checkOutput("b2b/rdata", bus.rsp_rdata_o, b_rdata[i-1]);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("b2b/rsp_valid_last", 32'(bus.rsp_valid_o), 32'd1);
        checkOutput("b2b/rdata_last", bus.rsp_rdata_o, b_rdata[2]);
        @(negedge clk);
        checkOutput("b2b/pulse_end", 32'(bus.rsp_valid_o), 32'd0);
        @(posedge clk);
        #1;

        // Misaligned word across words 4 and 5
        applyStimulus("sw_14", 1'b1, 3'b010, 32'h14, 32'hCAFE_F00D);
        applyStimulus("lw_12", 1'b0, 3'b010, 32'h12, 32'h0);
`ifdef DMEM_LSU_MISALIGN_EN
        checkOutput("lw_12/const", t_rdata, 32'hF00D_DEAD);
        checkOutput("lw_12/re", 32'(t_re), 32'd1);
`else
        checkOutput("lw_12/re", 32'(t_re), 32'd0);
`endif

        // Split store at offset 3, then wrap of a split load at the top word
        applyStimulus("sw_1f", 1'b1, 3'b010, 32'h1F, 32'hA1B2_C3D4);
`ifdef DMEM_LSU_MISALIGN_EN
        checkOutput("sw_1f/wstrb", 32'(t_strb), 32'b1000);
`else
        checkOutput("sw_1f/wstrb", 32'(t_strb), 32'b0000);
`endif
        applyStimulus("lw_1c", 1'b0, 3'b010, 32'h1C, 32'h0);
        applyStimulus("lw_20", 1'b0, 3'b010, 32'h20, 32'h0);
        applyStimulus("sw_top", 1'b1, 3'b010, 32'h0, 32'h0BAD_F00D);
        applyStimulus("lw_wrap", 1'b0, 3'b010, 32'hABCD_0000 | 32'(NBYTES - 2), 32'h0);

        // Illegal funct3
        applyStimulus("ld_f3_7", 1'b0, 3'b111, 32'h10, 32'h0);
        checkOutput("ld_f3_7/re", 32'(t_re), 32'd0);
        applyStimulus("st_f3_3", 1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF);
        checkOutput("st_f3_3/we", 32'(t_we), 32'd0);

        // Reset right after accepting a (split, if enabled) load: no response
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b010;
        bus.req_addr_i   = 32'h16;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid/rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("rst_mid/ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        checkOutput("rst_mid/no_late_rsp", 32'(bus.rsp_valid_o), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                r_f3 = 3'($urandom_range(0, 7));
            end else if (r_we) begin
                r_f3 = 3'($urandom_range(0, 2));
            end else begin
                k    = int'($urandom_range(0, 4));
                r_f3 = (k < 3) ? 3'(k) : 3'(k + 1);
            end
            r_addr = $urandom();
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            applyStimulus("rand", r_we, r_f3, r_addr, $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
